spi_cfg_master: RTL

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_master.sv | 124 ++++++++++++
 1 files changed

// File: rtl/spi_cfg_master.sv
// SPI mode-0 configuration master: one 16-bit register write/read frame per start.
// Frame layout {rw, 1'b0, addr, wdata|8'h00}, shifted MSB first.
module spi_cfg_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] tx_sh;
  logic [15:0] rx_sh;
  logic        rw_q;
  logic        div_end;

  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rw_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= SETUP;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            rw_q    <= rw;
            tx_sh   <= {rw, 1'b0, addr, (rw ? wdata : 8'h00)};
            mosi    <= rw;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (div_end) begin
            state   <= SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              // rising sclk: capture peripheral data
              rx_sh <= {rx_sh[14:0], miso};
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd15) begin
                state <= HOLD;
                if (!rw_q) rdata <= rx_sh[7:0];
              end else begin
                mosi  <= tx_sh[14];
                tx_sh <= {tx_sh[14:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (div_end) begin
            state   <= GAP;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (div_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
